// File: rtl/vx_mask_scanner_pkg.sv
// rtl/vx_mask_scanner_pkg.sv - shared helpers for the mask scanner
package vx_mask_scanner_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beats a mask with pop set bits takes to drain; an empty mask still takes one beat
  function automatic int beat_count(input int pop, input int lanes);
    return (pop == 0) ? 1 : (pop + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/vx_mask_scanner_if.sv
// rtl/vx_mask_scanner_if.sv - mask-in / index-beat-out handshake bundle
interface vx_mask_scanner_if
  import vx_mask_scanner_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 2,
  parameter int TAG_W = 4
) ();
  localparam int LN = log2up(N);

  logic                  valid_in;
  logic [N-1:0]          data_in;
  logic [TAG_W-1:0]      tag_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [LANES*LN-1:0]   data_out;
  logic [LANES-1:0]      mask_out;
  logic [TAG_W-1:0]      tag_out;
  logic                  last_out;
  logic                  ready_out;

  modport master (
    output valid_in, data_in, tag_in, ready_out,
    input  ready_in, valid_out, data_out, mask_out, tag_out, last_out
  );

  modport slave (
    input  valid_in, data_in, tag_in, ready_out,
    output ready_in, valid_out, data_out, mask_out, tag_out, last_out
  );
endinterface

// File: rtl/vx_mask_scanner_pick.sv
// rtl/vx_mask_scanner_pick.sv - combinational find-first-set returning index and one-hot
module vx_mask_scanner_pick
  import vx_mask_scanner_pkg::*;
#(
  parameter int N       = 16,
  parameter int REVERSE = 0
) (
  input  logic [N-1:0]           i_req,
  output logic                   o_valid,
  output logic [log2up(N)-1:0]   o_index,
  output logic [N-1:0]           o_onehot
);
  localparam int LN = log2up(N);

  always_comb begin
    o_valid  = 1'b0;
    o_index  = '0;
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[(REVERSE != 0) ? (N - 1 - i) : i]) begin
        o_valid = 1'b1;
        o_index = LN'((REVERSE != 0) ? (N - 1 - i) : i);
        o_onehot[(REVERSE != 0) ? (N - 1 - i) : i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vx_mask_scanner.sv
// rtl/vx_mask_scanner.sv - drains a request mask into beats of up to LANES set-bit indices
module vx_mask_scanner
  import vx_mask_scanner_pkg::*;
#(
  parameter int N       = 16,
  parameter int LANES   = 2,
  parameter int REVERSE = 0,
  parameter int TAG_W   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  vx_mask_scanner_if.slave bus
);
  localparam int LN = log2up(N);

  logic                        r_busy;
  logic [N-1:0]                r_rem;
  logic [TAG_W-1:0]            r_tag;

  logic [LANES-1:0]            w_lane_valid;
  logic [LANES-1:0][LN-1:0]    w_lane_idx;
  logic [N-1:0]                w_emitted;
  logic                        w_last;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_fire;

  // Each lane sees what the higher-priority lanes left behind; w_acc tracks bits taken so far
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [N-1:0] w_req;
    logic [N-1:0] w_hot;
    logic [N-1:0] w_acc;

    if (k == 0) begin : g_head
      assign w_req = r_rem;
      assign w_acc = w_hot;
    end else begin : g_tail
      assign w_req = g_lane[k-1].w_req & ~g_lane[k-1].w_hot;
      assign w_acc = g_lane[k-1].w_acc | w_hot;
    end

    vx_mask_scanner_pick #(
      .N       (N),
      .REVERSE (REVERSE)
    ) u_pick (
      .i_req    (w_req),
      .o_valid  (w_lane_valid[k]),
      .o_index  (w_lane_idx[k]),
      .o_onehot (w_hot)
    );
  end

  assign w_emitted = g_lane[LANES-1].w_acc;
  assign w_last    = r_busy && ((r_rem & ~w_emitted) == '0);
  assign w_fire    = r_busy && bus.ready_out;
  assign w_ready   = !r_busy || (bus.ready_out && w_last);
  assign w_accept  = bus.valid_in && w_ready;

  assign bus.ready_in  = w_ready;
  assign bus.valid_out = r_busy;
  assign bus.data_out  = w_lane_idx;
  assign bus.mask_out  = w_lane_valid;
  assign bus.tag_out   = r_tag;
  assign bus.last_out  = w_last;

  // A new mask accepted on the final beat overwrites rem directly, so there is no idle bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_tag  <= '0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_rem  <= bus.data_in;
      r_tag  <= bus.tag_in;
    end else if (w_fire) begin
      r_rem <= r_rem & ~w_emitted;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule
